// File: rtl/fc_pkg.sv
// Shared constants and types for the fully-connected head sequencer.
//   DW/FRAC  : Q8.8 activation, weight and bias format
//   ACCW     : accumulator width (no wrap over 120 full-scale products)
//   N_IN/N_HID/N_OUT : layer sizes 120 -> 84 -> 10
//   *_AW     : address widths of the ROMs and buffers
//   state_t  : sequencer FSM states
package fc_pkg;
  localparam int DW     = 16;
  localparam int FRAC   = 8;
  localparam int ACCW   = 40;
  localparam int N_IN   = 120;
  localparam int N_HID  = 84;
  localparam int N_OUT  = 10;

  localparam int IN_AW  = 7;
  localparam int W1_AW  = 14;
  localparam int B1_AW  = 7;
  localparam int HID_AW = 7;
  localparam int W2_AW  = 10;
  localparam int B2_AW  = 4;
  localparam int CNT_W  = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_MAC,
    S_DRAIN,
    S_WB,
    S_DONE
  } state_t;
endpackage

// File: rtl/fc_mac_unit.sv
// Single signed 16x16 multiply-accumulate with Q8.8 result formatting.
//   clk, rst_n  : clock, asynchronous active-low reset (acc cleared)
//   i_clear     : load acc with the bias aligned to Q16.16 (priority over i_en)
//   i_en        : add the current a*b product into acc
//   i_relu_en   : clamp negative results to zero
//   i_bias/i_a/i_b : Q8.8 operands
//   o_result    : (acc >>> FRAC) saturated to 16 bits, optional ReLU
module fc_mac_unit
  import fc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clear,
  input  logic                 i_en,
  input  logic                 i_relu_en,
  input  logic signed [DW-1:0] i_bias,
  input  logic signed [DW-1:0] i_a,
  input  logic signed [DW-1:0] i_b,
  output logic        [DW-1:0] o_result
);
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(32767);
  localparam logic signed [ACCW-1:0] SAT_MIN = -ACCW'(32768);

  logic signed [ACCW-1:0] r_acc;
  logic signed [2*DW-1:0] w_prod;
  logic signed [ACCW-1:0] w_prod_ext;
  logic signed [ACCW-1:0] w_bias_ext;
  logic signed [ACCW-1:0] w_acc_sh;
  logic        [DW-1:0]   w_sat;

  assign w_prod     = i_a * i_b;
  assign w_prod_ext = {{(ACCW-2*DW){w_prod[2*DW-1]}}, w_prod};
  // Bias is Q8.8; products are Q16.16, so the bias enters shifted by FRAC.
  assign w_bias_ext = {{(ACCW-DW-FRAC){i_bias[DW-1]}}, i_bias, {FRAC{1'b0}}};
  // Arithmetic shift floors toward -inf, which is the intended rounding.
  assign w_acc_sh   = r_acc >>> FRAC;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    w_sat = w_acc_sh[DW-1:0];
    if (w_acc_sh > SAT_MAX)      w_sat = 16'h7FFF;
    else if (w_acc_sh < SAT_MIN) w_sat = 16'h8000;
    o_result = (i_relu_en && w_sat[DW-1]) ? '0 : w_sat;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_acc <= '0;
    else if (i_clear) r_acc <= w_bias_ext;
    else if (i_en)    r_acc <= r_acc + w_prod_ext;
  end
endmodule

// File: rtl/fc_layer_sequencer.sv
// Sequences the CNN head: dense 120->84 with ReLU, then dense 84->10 linear.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start/busy/done   : run request (IDLE only), run in progress, end-of-run pulse
//   in_addr/in_data   : input-vector buffer read (1-cycle latency)
//   w1_*/b1_*         : layer-1 weight (n*120+i) and bias (n) ROMs
//   hid_we/waddr/wdata: hidden-buffer write of the post-ReLU activation
//   hid_raddr/rdata   : hidden-buffer read for layer 2
//   w2_*/b2_*         : layer-2 weight (k*84+j) and bias (k) ROMs
//   out_valid/ready/idx/data : class-score stream, held until accepted
module fc_layer_sequencer
  import fc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [IN_AW-1:0]  in_addr,
  input  logic [DW-1:0]     in_data,
  output logic [W1_AW-1:0]  w1_addr,
  input  logic [DW-1:0]     w1_data,
  output logic [B1_AW-1:0]  b1_addr,
  input  logic [DW-1:0]     b1_data,
  output logic              hid_we,
  output logic [HID_AW-1:0] hid_waddr,
  output logic [DW-1:0]     hid_wdata,
  output logic [HID_AW-1:0] hid_raddr,
  input  logic [DW-1:0]     hid_rdata,
  output logic [W2_AW-1:0]  w2_addr,
  input  logic [DW-1:0]     w2_data,
  output logic [B2_AW-1:0]  b2_addr,
  input  logic [DW-1:0]     b2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [B2_AW-1:0]  out_idx,
  output logic [DW-1:0]     out_data
);
  state_t             r_state;
  logic               r_layer;  // 0 = layer 1, 1 = layer 2
  logic [CNT_W-1:0]   r_n;      // output neuron
  logic [CNT_W-1:0]   r_i;      // input index whose address is on the bus

  logic               w_last_i;
  logic               w_last_n;
  logic               w_mac_clear;
  logic               w_mac_en;
  logic signed [DW-1:0] w_a;
  logic signed [DW-1:0] w_b;
  logic signed [DW-1:0] w_bias;
  logic [DW-1:0]      w_result;
  logic [W1_AW-1:0]   w_w1_base;
  logic [W2_AW-1:0]   w_w2_base;

  assign w_last_i  = (r_i == (r_layer ? CNT_W'(N_HID-1) : CNT_W'(N_IN-1)));
  assign w_last_n  = (r_n == (r_layer ? CNT_W'(N_OUT-1) : CNT_W'(N_HID-1)));
  assign w_w1_base = W1_AW'(r_n) * W1_AW'(N_IN);
  assign w_w2_base = W2_AW'(r_n) * W2_AW'(N_HID);

  // Data on the bus always belongs to the previous cycle's address: the
  // first MAC cycle sees the bias, later MAC cycles and DRAIN see products.
  assign w_mac_clear = (r_state == S_MAC) && (r_i == '0);
  assign w_mac_en    = ((r_state == S_MAC) && (r_i != '0)) || (r_state == S_DRAIN);
  assign w_a         = r_layer ? hid_rdata : in_data;
  assign w_b         = r_layer ? w2_data   : w1_data;
  assign w_bias      = r_layer ? b2_data   : b1_data;

  fc_mac_unit u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_mac_clear),
    .i_en      (w_mac_en),
    .i_relu_en (~r_layer),
    .i_bias    (w_bias),
    .i_a       (w_a),
    .i_b       (w_b),
    .o_result  (w_result)
  );

  // The accumulator is frozen in WB, so the result is stable for the write
  // strobe and for the whole time a score waits on out_ready.
  assign hid_wdata = w_result;
  assign out_data  = w_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_layer   <= 1'b0;
      r_n       <= '0;
      r_i       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_addr   <= '0;
      w1_addr   <= '0;
      b1_addr   <= '0;
      hid_we    <= 1'b0;
      hid_waddr <= '0;
      hid_raddr <= '0;
      w2_addr   <= '0;
      b2_addr   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            r_layer <= 1'b0;
            r_n     <= '0;
            b1_addr <= '0;
            r_state <= S_BIAS;
          end
        end
        S_BIAS: begin
          r_i     <= '0;
          r_state <= S_MAC;
          if (r_layer) begin
            hid_raddr <= '0;
            w2_addr   <= w_w2_base;
          end else begin
            in_addr <= '0;
            w1_addr <= w_w1_base;
          end
        end
        S_MAC: begin
          if (w_last_i) begin
            r_state <= S_DRAIN;
          end else begin
            r_i <= r_i + CNT_W'(1);
            if (r_layer) begin
              hid_raddr <= hid_raddr + HID_AW'(1);
              w2_addr   <= w2_addr + W2_AW'(1);
            end else begin
              in_addr <= in_addr + IN_AW'(1);
              w1_addr <= w1_addr + W1_AW'(1);
            end
          end
        end
        S_DRAIN: begin
          r_state <= S_WB;
          if (r_layer) begin
            out_valid <= 1'b1;
            out_idx   <= r_n[B2_AW-1:0];
          end else begin
            hid_we    <= 1'b1;
            hid_waddr <= r_n;
          end
        end
        S_WB: begin
          if (!r_layer) begin
            hid_we  <= 1'b0;
            r_state <= S_BIAS;
            if (w_last_n) begin
              r_layer <= 1'b1;
              r_n     <= '0;
              b2_addr <= '0;
            end else begin
              r_n     <= r_n + CNT_W'(1);
              b1_addr <= r_n + B1_AW'(1);
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (w_last_n) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_n     <= r_n + CNT_W'(1);
              b2_addr <= r_n[B2_AW-1:0] + B2_AW'(1);
              r_state <= S_BIAS;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Self-checking bench for fc_layer_sequencer: ROM/buffer models, a reference
// model that fills hidden-write and score scoreboards, and directed runs.
module tb_fc_layer_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [6:0]  in_addr;
  logic [15:0] in_data;
  logic [13:0] w1_addr;
  logic [15:0] w1_data;
  logic [6:0]  b1_addr;
  logic [15:0] b1_data;
  logic        hid_we;
  logic [6:0]  hid_waddr;
  logic [15:0] hid_wdata;
  logic [6:0]  hid_raddr;
  logic [15:0] hid_rdata;
  logic [9:0]  w2_addr;
  logic [15:0] w2_data;
  logic [3:0]  b2_addr;
  logic [15:0] b2_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_idx;
  logic [15:0] out_data;

  logic signed [15:0] in_mem  [128];
  logic signed [15:0] w1_mem  [16384];
  logic signed [15:0] b1_mem  [128];
  logic signed [15:0] hid_mem [128];
  logic signed [15:0] w2_mem  [1024];
  logic signed [15:0] b2_mem  [16];

  logic [22:0] hid_q [$];   // {addr, data}
  logic [19:0] out_q [$];   // {idx, data}
  int          hid_cnt [128];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  fc_layer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_addr(in_addr), .in_data(in_data),
    .w1_addr(w1_addr), .w1_data(w1_data),
    .b1_addr(b1_addr), .b1_data(b1_data),
    .hid_we(hid_we), .hid_waddr(hid_waddr), .hid_wdata(hid_wdata),
    .hid_raddr(hid_raddr), .hid_rdata(hid_rdata),
    .w2_addr(w2_addr), .w2_data(w2_data),
    .b2_addr(b2_addr), .b2_data(b2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_data(out_data)
  );

  // Synchronous memories, one cycle read latency.
  always @(posedge clk) begin
    in_data   <= in_mem[in_addr];
    w1_data   <= w1_mem[w1_addr];
    b1_data   <= b1_mem[b1_addr];
    hid_rdata <= hid_mem[hid_raddr];
    w2_data   <= w2_mem[w2_addr];
    b2_data   <= b2_mem[b2_addr];
    if (hid_we) hid_mem[hid_waddr] <= hid_wdata;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Q16.16 accumulator -> Q8.8 with floor, saturation and optional ReLU.
  function automatic logic [15:0] q_result(input longint acc, input bit relu);
    longint r;
    logic [15:0] v;
    r = acc >>> 8;
    if (r > 32767)       v = 16'h7FFF;
    else if (r < -32768) v = 16'h8000;
    else                 v = r[15:0];
    if (relu && v[15]) v = 16'h0000;
    return v;
  endfunction

  task automatic build_expect();
    logic [15:0] hid_m [84];
    longint acc;
    hid_q.delete();
    out_q.delete();
    for (int a = 0; a < 128; a++) hid_cnt[a] = 0;
    for (int n = 0; n < 84; n++) begin
      acc = longint'(b1_mem[n]) * 256;
      for (int i = 0; i < 120; i++)
        acc += longint'(in_mem[i]) * longint'(w1_mem[n*120+i]);
      hid_m[n] = q_result(acc, 1'b1);
      hid_q.push_back({7'(n), hid_m[n]});
    end
    for (int k = 0; k < 10; k++) begin
      acc = longint'(b2_mem[k]) * 256;
      for (int j = 0; j < 84; j++)
        acc += longint'($signed(hid_m[j])) * longint'(w2_mem[k*84+j]);
      out_q.push_back({4'(k), q_result(acc, 1'b0)});
    end
  endtask

  task automatic fill(input logic [15:0] in_v, w1_v, b1_v, w2_v, b2_v);
    for (int a = 0; a < 128; a++)   in_mem[a] = in_v;
    for (int a = 0; a < 16384; a++) w1_mem[a] = w1_v;
    for (int a = 0; a < 128; a++)   b1_mem[a] = b1_v;
    for (int a = 0; a < 1024; a++)  w2_mem[a] = w2_v;
    for (int a = 0; a < 16; a++)    b2_mem[a] = b2_v;
  endtask

  task automatic fill_random();
    for (int a = 0; a < 128; a++)   in_mem[a] = 16'(int'($urandom_range(1023)) - 512);
    for (int a = 0; a < 16384; a++) w1_mem[a] = 16'(int'($urandom_range(127)) - 64);
    for (int a = 0; a < 128; a++)   b1_mem[a] = 16'(int'($urandom_range(511)) - 256);
    for (int a = 0; a < 1024; a++)  w2_mem[a] = 16'(int'($urandom_range(127)) - 64);
    for (int a = 0; a < 16; a++)    b2_mem[a] = 16'(int'($urandom_range(511)) - 256);
  endtask

  // Scoreboard monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && hid_we) begin
      logic [22:0] e;
      e = (hid_q.size() > 0) ? hid_q.pop_front() : 23'h7FFFFF;
      check("hid_write", 64'({hid_waddr, hid_wdata}), 64'(e));
      hid_cnt[hid_waddr]++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [19:0] e;
      e = (out_q.size() > 0) ? out_q.pop_front() : 20'hFFFFF;
      check("score", 64'({out_idx, out_data}), 64'(e));
    end
  end

  task automatic do_run(input string tag, input int stall_idx, input int abort_at,
                        input int poke_at, input int exp_cycles, input bit addr_chk);
    int          cyc;
    int          stall_obs;
    bit          got_done;
    bit          stall_on;
    bit          prev_hs;
    int          bad;
    logic [63:0] snap;
    logic [63:0] tup;
    build_expect();
    out_ready = 1'b1;
    stall_obs = 0;
    stall_on  = 1'b0;
    prev_hs   = 1'b0;
    got_done  = 1'b0;
    snap      = '0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1;
    check({tag, "_busy_on"}, 64'(busy), 64'd1);
    for (int c = 0; c < exp_cycles + 50 && !got_done; c++) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == poke_at);
      if (abort_at > 0 && cyc == abort_at) begin
        rst_n = 1'b0;
        #1;
        check({tag, "_abort_busy"},  64'(busy), 64'd0);
        check({tag, "_abort_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_abort_we"},    64'(hid_we), 64'd0);
        check({tag, "_abort_addr"},  64'({in_addr, w1_addr}), 64'd0);
        #2 rst_n = 1'b1;
        start = 1'b0;
        hid_q.delete();
        out_q.delete();
        return;
      end
      if (stall_idx > 0) begin
        if (prev_hs) begin
          out_ready = 1'b0;
          stall_on  = 1'b1;
        end
        tup = 64'({out_valid, out_idx, out_data, w2_addr, hid_raddr, b2_addr, busy, done});
        if (stall_on && out_valid && out_idx == 4'(stall_idx)) begin
          stall_obs++;
          if (stall_obs == 1) snap = tup;
          else check({tag, "_stall_hold"}, tup, snap);
          if (stall_obs == 6) begin
            out_ready = 1'b1;
            stall_on  = 1'b0;
          end
        end
        prev_hs = out_valid && out_ready && (out_idx == 4'(stall_idx - 1));
      end
      if (addr_chk) begin
        if (cyc == 3)     check({tag, "_addr_n0i1"},   64'({in_addr, w1_addr, b1_addr}), 64'({7'd1, 14'd1, 7'd0}));
        if (cyc == 126)   check({tag, "_addr_n1i1"},   64'({in_addr, w1_addr, b1_addr}), 64'({7'd1, 14'd121, 7'd1}));
        if (cyc == 10330) check({tag, "_addr_last1"},  64'({in_addr, w1_addr, b1_addr}), 64'({7'd119, 14'd10079, 7'd83}));
        if (cyc == 10509) check({tag, "_addr_k2j1"},   64'({hid_raddr, w2_addr, b2_addr}), 64'({7'd1, 10'd169, 4'd2}));
        if (cyc == 10600) check({tag, "_addr_w1_hold"}, 64'(w1_addr), 64'd10079);
      end
      if (done) begin
        got_done = 1'b1;
        check({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cycles));
        check({tag, "_busy_off"},   64'(busy), 64'd0);
      end
    end
    check({tag, "_done_seen"}, 64'(got_done), 64'd1);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_hid_left"},   64'(hid_q.size()), 64'd0);
    check({tag, "_score_left"}, 64'(out_q.size()), 64'd0);
    bad = 0;
    for (int a = 0; a < 128; a++)
      if (hid_cnt[a] != ((a < 84) ? 1 : 0)) bad++;
    check({tag, "_hid_once"}, 64'(bad), 64'd0);
  endtask

  initial begin
    #12;
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_we",    64'(hid_we), 64'd0);
    check("rst_addrs", 64'({in_addr, w1_addr, b1_addr, hid_waddr, hid_raddr, w2_addr, b2_addr, out_idx}), 64'd0);
    check("rst_data",  64'(out_data), 64'd0);
    rst_n = 1'b1;

    // Constant weights: hidden 1.0 everywhere, scores 84.5 = 0x5480.
    fill(16'h1234, 16'h0000, 16'h0100, 16'h0100, 16'h0080);
    check("model_t1", 64'(q_result(longint'(84) * 65536 + 32768, 1'b0)), 64'h5480);
    do_run("t1", 0, 0, 0, 11203, 1'b0);

    // Saturation high, then saturation low followed by ReLU (first neurons only).
    fill(16'h7FFF, 16'h7FFF, 16'h0000, 16'h0001, 16'h0000);
    do_run("t2a", 0, 374, 0, 11203, 1'b0);
    fill(16'h7FFF, 16'h8000, 16'h0000, 16'h0001, 16'h0000);
    do_run("t2b", 0, 374, 0, 11203, 1'b0);

    // Negative bias only: ReLU in layer 1, none in layer 2.
    fill(16'h0100, 16'h0000, 16'hFF00, 16'h0000, 16'hFF00);
    do_run("t3", 0, 0, 0, 11203, 1'b0);

    // Random data, address probes and a 5-cycle stall on score 3.
    fill_random();
    do_run("t45", 3, 0, 0, 11208, 1'b1);

    // Abort mid-run, then restart with a start pulse during busy.
    fill(16'h1234, 16'h0000, 16'h0100, 16'h0100, 16'h0080);
    do_run("t6a", 0, 500, 0, 11203, 1'b0);
    do_run("t6b", 0, 0, 2000, 11203, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
